fifo_drain_stage: RTL and testbench

- Downstream consumer of the two-stage FIFO chain.
- Pops the last FIFO (first-word-fall-through head on `fifo_data` whenever `!fifo_empty`) into a 2-entry skid buffer.
- Presents entries on a valid/ready output port, tagged with a wrapping sequence number.
- Decouples downstream backpressure from the FIFO pop path: `fifo_pop` depends only on registered state, `fifo_empty` and `en`, never on `out_rdy`.

---
 rtl/fifo_drain_if.sv | 26 ++
 rtl/fifo_drain_stage.sv | 128 ++++++++++++
 tb/tb_fifo_drain_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_if.sv
// Handshake bundle between the last FIFO, the drain stage and the downstream consumer.
// The slave modport is the drain stage's view; master is the environment driving it.
interface fifo_drain_if #(
  parameter int WIDTH = 8,
  parameter int SEQW  = 4
);
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic [SEQW-1:0]  out_seq;
  logic [1:0]       count;

  modport slave (
    input  en, fifo_empty, fifo_data, out_rdy,
    output fifo_pop, out_vld, out_data, out_seq, count
  );

  modport master (
    output en, fifo_empty, fifo_data, out_rdy,
    input  fifo_pop, out_vld, out_data, out_seq, count
  );
endinterface

// File: rtl/fifo_drain_stage.sv
// Drains a first-word-fall-through FIFO into a 2-entry skid buffer with sequence tags.
// Optional macro DRAIN_STALL_CNT_EN adds a saturating backpressure stall counter output.
module fifo_drain_stage #(
  parameter int WIDTH = 8,
  parameter int SEQW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  fifo_drain_if.slave bus
`ifdef DRAIN_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  e0_q, e0_d;
  logic [WIDTH-1:0]  e1_q, e1_d;
  logic [SEQW-1:0]   t0_q, t0_d;
  logic [SEQW-1:0]   t1_q, t1_d;
  logic [SEQW-1:0]   tag_q, tag_d;
  logic              accept;
  logic              drain;

  // Pop depends only on registered occupancy, never on out_rdy, so the
  // downstream ready path stays isolated from the FIFO pop path.
  always_comb begin
    accept = bus.en && !bus.fifo_empty && (state_q != TWO) && !rst;
    drain  = (state_q != ZERO) && bus.out_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ZERO;
      e0_q    <= '0;
      e1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    tag_d   = accept ? SEQW'(tag_q + 1'b1) : tag_q;
    unique case (state_q)
      ZERO: begin
        if (accept) begin
          state_d = ONE;
          e0_d    = bus.fifo_data;
          t0_d    = tag_q;
        end
      end
      ONE: begin
        if (accept && drain) begin
          e0_d = bus.fifo_data;
          t0_d = tag_q;
        end else if (accept) begin
          state_d = TWO;
          e1_d    = bus.fifo_data;
          t1_d    = tag_q;
        end else if (drain) begin
          state_d = ZERO;
        end
      end
      TWO: begin
        // The second slot shifts forward so the head always lives in e0.
        if (drain) begin
          state_d = ONE;
          e0_d    = e1_q;
          t0_d    = t1_q;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  always_comb begin
    bus.fifo_pop = accept;
    bus.out_vld  = (state_q != ZERO);
    bus.out_data = e0_q;
    bus.out_seq  = t0_q;
    bus.count    = state_q;
  end

`ifdef DRAIN_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ZERO) && !bus.out_rdy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  stall_cnt_monotonic: assert property (
    @(posedge clk) disable iff (rst) (stall_cnt_q >= $past(stall_cnt_q))
  );
`endif

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Directed and randomized bench for fifo_drain_stage against a queue-based buffer model.
module tb_fifo_drain_stage;

  localparam int WIDTH = 8;
  localparam int SEQW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_drain_if #(.WIDTH(WIDTH), .SEQW(SEQW)) bus ();

`ifdef DRAIN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fifo_drain_stage #(.WIDTH(WIDTH), .SEQW(SEQW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef DRAIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [WIDTH-1:0]      fifo_q[$];
  logic [SEQW+WIDTH-1:0] mbuf[$];
  logic [SEQW+WIDTH-1:0] deliv_q[$];
  logic [WIDTH-1:0]      sent_q[$];
  logic [SEQW-1:0]       mtag = '0;
  int unsigned           pops_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic refresh_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    refresh_fifo();
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic exp_pop;
    logic drained;
    @(negedge clk);
    exp_pop = bus.en && (fifo_q.size() != 0) && (mbuf.size() < 2) && !rst;
    drained = (mbuf.size() != 0) && bus.out_rdy;
    chk("fifo_pop", 32'(bus.fifo_pop), 32'(exp_pop));
    chk("out_vld",  32'(bus.out_vld),  32'(mbuf.size() != 0));
    chk("count",    32'(bus.count),    32'(mbuf.size()));
    if (mbuf.size() != 0) begin
      chk("out_data", 32'(bus.out_data), 32'(mbuf[0][WIDTH-1:0]));
      chk("out_seq",  32'(bus.out_seq),  32'(mbuf[0][SEQW+WIDTH-1:WIDTH]));
    end
    if (bus.fifo_pop) pops_seen++;
    if (bus.out_vld && bus.out_rdy) deliv_q.push_back({bus.out_seq, bus.out_data});
    @(posedge clk);
    if (rst) begin
      mbuf.delete();
      mtag = '0;
    end else begin
      if (drained) void'(mbuf.pop_front());
      if (exp_pop) begin
        mbuf.push_back({mtag, fifo_q.pop_front()});
        mtag = mtag + 1'b1;
      end
    end
    #1;
    refresh_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int unsigned  base_tag;
    logic [15:0]  stall_before;
    stall_before = '0;
    bus.en      = 1'b0;
    bus.out_rdy = 1'b0;
    refresh_fifo();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld",  32'(bus.out_vld),  32'd0);
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_seq",  32'(bus.out_seq),  32'd0);
`ifdef DRAIN_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Three words, free-flowing; pop must stay low while rst is high
    push(8'hA1); push(8'hB2); push(8'hC3);
    bus.en = 1'b1; bus.out_rdy = 1'b1;
    #1;
    chk("pop_in_rst", 32'(bus.fifo_pop), 32'd0);
    cycle();
    rst = 1'b0;
    pops_seen = 0; deliv_q.delete();
    run(6);
    chk("t1_pops", pops_seen, 32'd3);
    chk("t1_n",    deliv_q.size(), 32'd3);
    if (deliv_q.size() == 3) begin
      chk("t1_w0", 32'(deliv_q[0]), 32'h0A1);
      chk("t1_w1", 32'(deliv_q[1]), 32'h1B2);
      chk("t1_w2", 32'(deliv_q[2]), 32'h2C3);
    end
    chk("t1_count", 32'(bus.count), 32'd0);

    // Backpressure: exactly two pops, head held
    bus.out_rdy = 1'b0;
    push(8'h31); push(8'h32); push(8'h33);
    pops_seen = 0; deliv_q.delete();
`ifdef DRAIN_STALL_CNT_EN
    stall_before = stall_cnt;
`endif
    run(6);
    chk("t2_pops",  pops_seen, 32'd2);
    chk("t2_count", 32'(bus.count), 32'd2);
    chk("t2_pop0",  32'(bus.fifo_pop), 32'd0);
    chk("t2_head",  32'(bus.out_data), 32'h31);
`ifdef DRAIN_STALL_CNT_EN
    chk("t2_stall", 32'(stall_cnt - stall_before), 32'd5);
`endif
    bus.out_rdy = 1'b1;
    run(5);
    chk("t2_n", deliv_q.size(), 32'd3);
    if (deliv_q.size() == 3) begin
      chk("t2_w0", 32'(deliv_q[0][WIDTH-1:0]), 32'h31);
      chk("t2_w1", 32'(deliv_q[1][WIDTH-1:0]), 32'h32);
      chk("t2_w2", 32'(deliv_q[2][WIDTH-1:0]), 32'h33);
    end

    // Simultaneous accept and drain at count=1
    bus.out_rdy = 1'b0;
    push(8'h11);
    run(2);
    chk("t3_count1", 32'(bus.count), 32'd1);
    chk("t3_head",   32'(bus.out_data), 32'h11);
    push(8'h22);
    bus.out_rdy = 1'b1;
    #1;
    chk("t3_pop", 32'(bus.fifo_pop), 32'd1);
    cycle();
    chk("t3_count_kept", 32'(bus.count), 32'd1);
    chk("t3_new_head",   32'(bus.out_data), 32'h22);
    run(2);

    // 17-word stream after reset: tags 0..15 then 0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    deliv_q.delete();
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    run(20);
    chk("t4_n", deliv_q.size(), 32'd17);
    for (int i = 0; i < deliv_q.size() && i < 17; i++) begin
      chk("t4_seq",  32'(deliv_q[i][SEQW+WIDTH-1:WIDTH]), 32'(i % 16));
      chk("t4_data", 32'(deliv_q[i][WIDTH-1:0]), 32'(8'h40 + i));
    end

    // Reset while full: entries discarded, FIFO remainder kept
    bus.out_rdy = 1'b0;
    push(8'h51); push(8'h52); push(8'h53);
    run(3);
    chk("t5_full", 32'(bus.count), 32'd2);
    rst = 1'b1;
    #1;
    chk("t5_pop_in_rst", 32'(bus.fifo_pop), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("t5_vld",  32'(bus.out_vld),  32'd0);
    chk("t5_cnt",  32'(bus.count),    32'd0);
    chk("t5_seq",  32'(bus.out_seq),  32'd0);
    chk("t5_pop",  32'(bus.fifo_pop), 32'd1);
    deliv_q.delete();
    bus.out_rdy = 1'b1;
    run(3);
    chk("t5_n", deliv_q.size(), 32'd1);
    if (deliv_q.size() == 1) chk("t5_w", 32'(deliv_q[0]), 32'h053);

    // Randomized traffic with end-to-end scoreboard
    deliv_q.delete(); sent_q.delete();
    base_tag = 32'(mtag);
    for (int i = 0; i < 400; i++) begin
      bus.en      = ($urandom_range(0, 3) != 0);
      bus.out_rdy = ($urandom_range(0, 2) != 0);
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        sent_q.push_back(8'($urandom));
        push(sent_q[$]);
      end
      cycle();
    end
    bus.en = 1'b1; bus.out_rdy = 1'b1;
    run(12);
    chk("rnd_n", deliv_q.size(), sent_q.size());
    for (int i = 0; i < deliv_q.size() && i < sent_q.size(); i++) begin
      chk("rnd_data", 32'(deliv_q[i][WIDTH-1:0]), 32'(sent_q[i]));
      chk("rnd_seq",  32'(deliv_q[i][SEQW+WIDTH-1:WIDTH]), (base_tag + i) % 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
